digi_clock_rtc: RTL and testbench

Parametrised successor to the team's fixed 100-tick digital clock. It divides `clk` by `CLK_DIV` into a 1 Hz tick and keeps a 24-hour sec/min/hr count. Over the old block it adds:
- synchronous reset and run/pause;
- validated time load;
- 12/24-hour display mode;
- rollover pulses and an HH:MM alarm.

It sits between the system clock and the display/alarm logic.

---
 rtl/digi_clock_rtc_if.sv | 36 +++
 rtl/digi_clock_rtc.sv | 120 ++++++++++++
 tb/tb_digi_clock_rtc.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/digi_clock_rtc_if.sv
// Control, load, alarm and time/pulse signals of the RTC, bundled between
// the controlling logic (master) and the clock core (slave).
interface digi_clock_rtc_if;
    logic       run;
    logic       mode_12h;
    logic       load;
    logic [4:0] ld_hr;
    logic [5:0] ld_min;
    logic [5:0] ld_sec;
    logic       alarm_en;
    logic [4:0] alarm_hr;
    logic [5:0] alarm_min;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
    logic [4:0] hr_disp;
    logic       pm;
    logic       sec_tick;
    logic       min_tick;
    logic       hr_tick;
    logic       day_tick;
    logic       alarm_hit;
    logic       load_err;

    modport master (
        output run, mode_12h, load, ld_hr, ld_min, ld_sec, alarm_en, alarm_hr, alarm_min,
        input  sec, min, hr, hr_disp, pm, sec_tick, min_tick, hr_tick, day_tick, alarm_hit,
               load_err
    );

    modport slave (
        input  run, mode_12h, load, ld_hr, ld_min, ld_sec, alarm_en, alarm_hr, alarm_min,
        output sec, min, hr, hr_disp, pm, sec_tick, min_tick, hr_tick, day_tick, alarm_hit,
               load_err
    );
endinterface

// File: rtl/digi_clock_rtc.sv
// 24-hour real-time clock: CLK_DIV prescaler, validated load, 12/24-hour
// display mapping, registered rollover pulses and an HH:MM alarm.
module digi_clock_rtc #(
    parameter int unsigned CLK_DIV = 100
) (
    input logic             clk,
    input logic             rst,
    digi_clock_rtc_if.slave bus
);
    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [5:0]      sec_q, sec_d, min_q, min_d;
    logic [4:0]      hr_q, hr_d;
    logic            sec_tick_q, sec_tick_d, min_tick_q, min_tick_d;
    logic            hr_tick_q, hr_tick_d, day_tick_q, day_tick_d;
    logic            alarm_hit_q, alarm_hit_d, load_err_q, load_err_d;

    logic ld_ok, do_load, tick, do_tick;
    logic sec_wrap, min_wrap, hr_wrap, alarm_ok;

    always_comb begin
        ld_ok    = (bus.ld_hr <= 5'd23) && (bus.ld_min <= 6'd59) && (bus.ld_sec <= 6'd59);
        do_load  = bus.load && ld_ok;
        tick     = bus.run && (cnt_q == CntMax);
        // a valid load swallows a coincident tick
        do_tick  = tick && !do_load;
        sec_wrap = (sec_q == 6'd59);
        min_wrap = (min_q == 6'd59);
        hr_wrap  = (hr_q == 5'd23);
        alarm_ok = (bus.alarm_hr <= 5'd23) && (bus.alarm_min <= 6'd59);

        cnt_d       = cnt_q;
        sec_d       = sec_q;
        min_d       = min_q;
        hr_d        = hr_q;
        sec_tick_d  = 1'b0;
        min_tick_d  = 1'b0;
        hr_tick_d   = 1'b0;
        day_tick_d  = 1'b0;
        alarm_hit_d = 1'b0;
        load_err_d  = bus.load && !ld_ok;

        if (do_load) begin
            cnt_d = '0;
            sec_d = bus.ld_sec;
            min_d = bus.ld_min;
            hr_d  = bus.ld_hr;
        end else begin
            if (bus.run) begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
            end
            if (do_tick) begin
                sec_tick_d = 1'b1;
                sec_d      = sec_wrap ? 6'd0 : sec_q + 6'd1;
                if (sec_wrap) begin
                    min_tick_d = 1'b1;
                    min_d      = min_wrap ? 6'd0 : min_q + 6'd1;
                    if (min_wrap) begin
                        hr_tick_d  = 1'b1;
                        hr_d       = hr_wrap ? 5'd0 : hr_q + 5'd1;
                        day_tick_d = hr_wrap;
                    end
                end
                // only a tick landing on sec 0 can hit, so it fires once per day
                alarm_hit_d = bus.alarm_en && alarm_ok && sec_wrap &&
                              (min_d == bus.alarm_min) && (hr_d == bus.alarm_hr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            hr_q        <= '0;
            sec_tick_q  <= 1'b0;
            min_tick_q  <= 1'b0;
            hr_tick_q   <= 1'b0;
            day_tick_q  <= 1'b0;
            alarm_hit_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hr_q        <= hr_d;
            sec_tick_q  <= sec_tick_d;
            min_tick_q  <= min_tick_d;
            hr_tick_q   <= hr_tick_d;
            day_tick_q  <= day_tick_d;
            alarm_hit_q <= alarm_hit_d;
            load_err_q  <= load_err_d;
        end
    end

    always_comb begin
        bus.hr_disp = hr_q;
        if (bus.mode_12h) begin
            if (hr_q == 5'd0) begin
                bus.hr_disp = 5'd12;
            end else if (hr_q > 5'd12) begin
                bus.hr_disp = hr_q - 5'd12;
            end
        end
    end

    assign bus.pm        = (hr_q >= 5'd12);
    assign bus.sec       = sec_q;
    assign bus.min       = min_q;
    assign bus.hr        = hr_q;
    assign bus.sec_tick  = sec_tick_q;
    assign bus.min_tick  = min_tick_q;
    assign bus.hr_tick   = hr_tick_q;
    assign bus.day_tick  = day_tick_q;
    assign bus.alarm_hit = alarm_hit_q;
    assign bus.load_err  = load_err_q;
endmodule

// File: tb/tb_digi_clock_rtc.sv
// Scoreboard bench for digi_clock_rtc at CLK_DIV=4: reset, ticking, rollover,
// load validation, 12-hour mapping, alarm and run/pause behaviour.
module tb_digi_clock_rtc;
    localparam int unsigned ClkDiv = 4;

    logic clk;
    logic rst;

    digi_clock_rtc_if bus ();

    digi_clock_rtc #(
        .CLK_DIV(ClkDiv)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            check_eq("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check_eq(e.tag, obs, e.val);
        end
    endtask

    // time as decimal HHMMSS
    function automatic logic [31:0] now_t();
        return 32'(bus.hr) * 10000 + 32'(bus.min) * 100 + 32'(bus.sec);
    endfunction

    // {sec_tick, min_tick, hr_tick, day_tick, alarm_hit, load_err}
    function automatic logic [31:0] pulses();
        return {26'd0, bus.sec_tick, bus.min_tick, bus.hr_tick, bus.day_tick, bus.alarm_hit,
                bus.load_err};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        bus.ld_hr  = h;
        bus.ld_min = m;
        bus.ld_sec = s;
        bus.load   = 1'b1;
        step(1);
        bus.load   = 1'b0;
    endtask

    task automatic wait_sec_tick(input int max, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!bus.sec_tick && n < max);
    endtask

    task automatic count_alarm(input int n, output int hits);
        hits = 0;
        repeat (n) begin
            step(1);
            if (bus.alarm_hit) hits++;
        end
    endtask

    int n;
    int hits;
    int bad;
    logic [4:0] bad_hr  [3] = '{5'd24, 5'd0, 5'd0};
    logic [5:0] bad_min [3] = '{6'd0, 6'd60, 6'd0};
    logic [5:0] bad_sec [3] = '{6'd0, 6'd0, 6'd60};
    logic [4:0] m_hr    [4] = '{5'd0, 5'd12, 5'd23, 5'd13};
    logic [4:0] m_disp  [4] = '{5'd12, 5'd12, 5'd11, 5'd1};
    logic       m_pm    [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        rst           = 1'b1;
        bus.run       = 1'b0;
        bus.mode_12h  = 1'b0;
        bus.load      = 1'b0;
        bus.ld_hr     = '0;
        bus.ld_min    = '0;
        bus.ld_sec    = '0;
        bus.alarm_en  = 1'b0;
        bus.alarm_hr  = '0;
        bus.alarm_min = '0;

        // reset state
        sb_push("rst_time", 0);
        sb_push("rst_pulses", 0);
        sb_push("rst_hr_disp", 0);
        sb_push("rst_pm", 0);
        step(2);
        sb_check(now_t());
        sb_check(pulses());
        sb_check(32'(bus.hr_disp));
        sb_check(32'(bus.pm));

        // first tick at cycle CLK_DIV, then one second per CLK_DIV cycles
        rst     = 1'b0;
        bus.run = 1'b1;
        sb_push("first_tick_latency", 4);
        sb_push("first_tick_sec", 1);
        wait_sec_tick(10, n);
        sb_check(32'(n));
        sb_check(32'(bus.sec));
        sb_push("sec_after_40", 10);
        sb_push("pulse_at_40", 32);
        step(36);
        sb_check(32'(bus.sec));
        sb_check(pulses());

        // day rollover
        sb_push("ld_235958_time", 235958);
        sb_push("ld_235958_pulses", 0);
        do_load(5'd23, 6'd59, 6'd58);
        sb_check(now_t());
        sb_check(pulses());
        sb_push("t_235959", 235959);
        sb_push("t_235959_pulses", 32);
        step(4);
        sb_check(now_t());
        sb_check(pulses());
        sb_push("day_time", 0);
        sb_push("day_pulses", 60);
        step(4);
        sb_check(now_t());
        sb_check(pulses());
        sb_push("day_pulses_drop", 0);
        step(1);
        sb_check(pulses());

        // invalid loads leave time alone
        bus.run = 1'b0;
        do_load(5'd10, 6'd20, 6'd30);
        for (int i = 0; i < 3; i++) begin
            sb_push($sformatf("bad_load%0d_time", i), 102030);
            sb_push($sformatf("bad_load%0d_err", i), 1);
            sb_push($sformatf("bad_load%0d_err_drop", i), 0);
            do_load(bad_hr[i], bad_min[i], bad_sec[i]);
            sb_check(now_t());
            sb_check(pulses());
            step(1);
            sb_check(pulses());
        end

        // rejected load does not block a pending tick
        bus.run = 1'b1;
        step(3);
        sb_push("bad_load_tick_time", 102031);
        sb_push("bad_load_tick_pulses", 33);
        do_load(5'd24, 6'd0, 6'd0);
        sb_check(now_t());
        sb_check(pulses());

        // valid load beats a coincident tick and restarts the prescaler
        step(3);
        sb_push("load_vs_tick_time", 50607);
        sb_push("load_vs_tick_pulses", 0);
        sb_push("load_next_tick", 4);
        sb_push("load_next_tick_time", 50608);
        do_load(5'd5, 6'd6, 6'd7);
        sb_check(now_t());
        sb_check(pulses());
        wait_sec_tick(10, n);
        sb_check(32'(n));
        sb_check(now_t());

        // 12-hour mapping
        bus.run      = 1'b0;
        bus.mode_12h = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb_push($sformatf("m12_hr%0d_disp", m_hr[i]), 32'(m_disp[i]));
            sb_push($sformatf("m12_hr%0d_pm", m_hr[i]), 32'(m_pm[i]));
            sb_push($sformatf("m12_hr%0d_hr", m_hr[i]), 32'(m_hr[i]));
            do_load(m_hr[i], 6'd0, 6'd0);
            sb_check(32'(bus.hr_disp));
            sb_check(32'(bus.pm));
            sb_check(32'(bus.hr));
        end
        bus.mode_12h = 1'b0;
        #1;
        sb_push("m24_disp", 13);
        sb_check(32'(bus.hr_disp));

        // alarm
        bus.run       = 1'b1;
        bus.alarm_en  = 1'b1;
        bus.alarm_hr  = 5'd7;
        bus.alarm_min = 6'd30;
        sb_push("alarm_ld_pulses", 0);
        sb_push("alarm_tick_latency", 4);
        sb_push("alarm_tick_pulses", 50);
        sb_push("alarm_tick_time", 73000);
        sb_push("alarm_no_repeat", 0);
        do_load(5'd7, 6'd29, 6'd59);
        sb_check(pulses());
        wait_sec_tick(10, n);
        sb_check(32'(n));
        sb_check(pulses());
        sb_check(now_t());
        count_alarm(4, hits);
        sb_check(32'(hits));

        sb_push("alarm_direct_ld_pulses", 0);
        sb_push("alarm_direct_ld_hits", 0);
        do_load(5'd7, 6'd30, 6'd0);
        sb_check(pulses());
        count_alarm(8, hits);
        sb_check(32'(hits));

        bus.alarm_en = 1'b0;
        sb_push("alarm_dis_hits", 0);
        sb_push("alarm_dis_time", 73001);
        do_load(5'd7, 6'd29, 6'd59);
        count_alarm(8, hits);
        sb_check(32'(hits));
        sb_check(now_t());

        bus.alarm_en = 1'b1;
        sb_push("alarm_mid_minute_hits", 0);
        count_alarm(8, hits);
        sb_check(32'(hits));
        bus.alarm_en = 1'b0;

        // pause mid-count
        do_load(5'd1, 6'd2, 6'd3);
        step(2);
        bus.run = 1'b0;
        bad     = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (pulses() != 0) bad++;
        end
        sb_push("pause_pulses", 0);
        sb_push("pause_time", 10203);
        sb_push("resume_latency", 2);
        sb_push("resume_time", 10204);
        sb_check(32'(bad));
        sb_check(now_t());
        bus.run = 1'b1;
        wait_sec_tick(10, n);
        sb_check(32'(n));
        sb_check(now_t());

        // reset mid-count overrides a tick and a load
        step(3);
        rst        = 1'b1;
        bus.ld_hr  = 5'd10;
        bus.ld_min = 6'd0;
        bus.ld_sec = 6'd0;
        bus.load   = 1'b1;
        sb_push("mid_rst_time", 0);
        sb_push("mid_rst_pulses", 0);
        sb_push("mid_rst_hr_disp", 0);
        sb_push("mid_rst_pm", 0);
        step(1);
        rst      = 1'b0;
        bus.load = 1'b0;
        sb_check(now_t());
        sb_check(pulses());
        sb_check(32'(bus.hr_disp));
        sb_check(32'(bus.pm));

        check_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
